// File: rtl/key_evt_pkg.sv
// Shared types for the key event encoder: channel states, event record, sizing helpers.
package key_evt_pkg;

   localparam int unsigned NUM_KEYS = 4;
   localparam int unsigned KEY_W    = 2;

   typedef enum logic [2:0] {
      StIdle,
      StPressDb,
      StHeld,
      StRepeat,
      StRelDb
   } key_state_e;

   typedef struct packed {
      logic             rpt;
      logic [KEY_W-1:0] code;
   } key_evt_t;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/key_event_encoder_channel.sv
// One key: 2-flop synchronizer, debounce / hold / auto-repeat FSM, registered level and flag.
module key_channel
   import key_evt_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = 1_000_000,
   parameter int unsigned HOLD_CYC     = 50_000_000,
   parameter int unsigned REPEAT_CYC   = 10_000_000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key,
   output logic o_value,
   output logic o_flag,
   output logic o_rpt
);

   localparam int unsigned CNT_W = $clog2(max3(DEBOUNCE_CYC, HOLD_CYC, REPEAT_CYC)) + 1;
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

   logic             r_sync1, r_sync2;
   key_state_e       r_state, w_state_d;
   logic [CNT_W-1:0] r_cnt, w_cnt_d;
   logic             r_armed, w_armed_d;
   logic             r_from_rpt, w_from_rpt_d;
   logic             r_value, w_value_d;
   logic             r_flag, w_flag_d;
   logic             r_rpt, w_rpt_d;
   logic             w_s;

   assign w_s = ~r_sync2;

   always_comb begin
      w_state_d    = r_state;
      w_cnt_d      = r_cnt;
      w_armed_d    = r_armed;
      w_from_rpt_d = r_from_rpt;
      w_value_d    = r_value;
      w_flag_d     = 1'b0;
      w_rpt_d      = 1'b0;
      case (r_state)
         StIdle: begin
            // After reset a key held down must be seen released for a debounce time first.
            if (!r_armed) begin
               if (w_s) begin
                  w_cnt_d = '0;
               end else if (r_cnt == DEB_LAST) begin
                  w_armed_d = 1'b1;
                  w_cnt_d   = '0;
               end else begin
                  w_cnt_d = r_cnt + CNT_W'(1);
               end
            end else if (w_s) begin
               w_state_d = StPressDb;
               w_cnt_d   = '0;
            end
         end
         StPressDb: begin
            if (!w_s) begin
               w_state_d = StIdle;
               w_cnt_d   = '0;
            end else if (r_cnt == DEB_LAST) begin
               w_state_d    = StHeld;
               w_value_d    = 1'b1;
               w_flag_d     = 1'b1;
               w_from_rpt_d = 1'b0;
               w_cnt_d      = '0;
            end else begin
               w_cnt_d = r_cnt + CNT_W'(1);
            end
         end
         StHeld: begin
            if (!w_s) begin
               w_state_d    = StRelDb;
               w_from_rpt_d = 1'b0;
               w_cnt_d      = '0;
            end else if (r_cnt == HOLD_LAST) begin
               w_state_d = StRepeat;
               w_flag_d  = 1'b1;
               w_rpt_d   = 1'b1;
               w_cnt_d   = '0;
            end else begin
               w_cnt_d = r_cnt + CNT_W'(1);
            end
         end
         StRepeat: begin
            if (!w_s) begin
               w_state_d    = StRelDb;
               w_from_rpt_d = 1'b1;
               w_cnt_d      = '0;
            end else if (r_cnt == REP_LAST) begin
               w_flag_d = 1'b1;
               w_rpt_d  = 1'b1;
               w_cnt_d  = '0;
            end else begin
               w_cnt_d = r_cnt + CNT_W'(1);
            end
         end
         StRelDb: begin
            if (w_s) begin
               w_state_d = r_from_rpt ? StRepeat : StHeld;
               w_cnt_d   = '0;
            end else if (r_cnt == DEB_LAST) begin
               w_state_d = StIdle;
               w_value_d = 1'b0;
               w_cnt_d   = '0;
            end else begin
               w_cnt_d = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1    <= 1'b1;
         r_sync2    <= 1'b1;
         r_state    <= StIdle;
         r_cnt      <= '0;
         r_armed    <= 1'b0;
         r_from_rpt <= 1'b0;
         r_value    <= 1'b0;
         r_flag     <= 1'b0;
         r_rpt      <= 1'b0;
      end else begin
         r_sync1    <= i_key;
         r_sync2    <= r_sync1;
         r_state    <= w_state_d;
         r_cnt      <= w_cnt_d;
         r_armed    <= w_armed_d;
         r_from_rpt <= w_from_rpt_d;
         r_value    <= w_value_d;
         r_flag     <= w_flag_d;
         r_rpt      <= w_rpt_d;
      end
   end

   assign o_value = r_value;
   assign o_flag  = r_flag;
   assign o_rpt   = r_rpt;

endmodule

// File: rtl/key_event_encoder.sv
// Key front end: four debounced channels, pending latches, priority arbiter and event FIFO.
module key_event_encoder
   import key_evt_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = 1_000_000,
   parameter int unsigned HOLD_CYC     = 50_000_000,
   parameter int unsigned REPEAT_CYC   = 10_000_000,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [NUM_KEYS-1:0] i_key,
   output logic [NUM_KEYS-1:0] o_key_value,
   output logic [NUM_KEYS-1:0] o_key_flag,
   output logic                o_evt_valid,
   output logic [KEY_W-1:0]    o_evt_code,
   output logic                o_evt_rpt,
   input  logic                i_evt_ready,
   output logic                o_beep_req,
   output logic                o_ovf
);

   localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   logic [NUM_KEYS-1:0] w_flag_rpt;
   logic [NUM_KEYS-1:0] r_pend, r_pend_rpt, w_pend_d, w_pend_rpt_d, w_grant;
   logic [KEY_W-1:0]    w_sel;
   logic                w_push, w_pop, w_drop, w_empty, w_full;
   logic [PTR_W-1:0]    r_wptr, r_rptr;
   key_evt_t            r_mem [FIFO_DEPTH];
   key_evt_t            w_push_evt, w_head;
   logic                r_beep, r_ovf;

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
      key_channel #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .HOLD_CYC     (HOLD_CYC),
         .REPEAT_CYC   (REPEAT_CYC)
      ) u_chan (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_key   (i_key[g]),
         .o_value (o_key_value[g]),
         .o_flag  (o_key_flag[g]),
         .o_rpt   (w_flag_rpt[g])
      );
   end

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[IDX_W] != r_rptr[IDX_W]) &&
                    (r_wptr[IDX_W-1:0] == r_rptr[IDX_W-1:0]);
   assign w_pop   = !w_empty && i_evt_ready;
   assign w_head  = r_mem[r_rptr[IDX_W-1:0]];

   // Lowest index wins; a pop in the same cycle frees the slot for the push.
   always_comb begin
      w_sel = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (r_pend[i]) w_sel = KEY_W'(i);
      end
      w_push     = (|r_pend) && (!w_full || w_pop);
      w_grant    = w_push ? (NUM_KEYS'(1) << w_sel) : '0;
      w_push_evt = '{rpt: r_pend_rpt[w_sel], code: w_sel};
   end

   always_comb begin
      w_pend_d     = r_pend & ~w_grant;
      w_pend_rpt_d = r_pend_rpt;
      w_drop       = 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (o_key_flag[i]) begin
            if (w_pend_d[i]) begin
               w_drop = 1'b1;
            end else begin
               w_pend_d[i]     = 1'b1;
               w_pend_rpt_d[i] = w_flag_rpt[i];
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pend     <= '0;
         r_pend_rpt <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_beep     <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_pend     <= w_pend_d;
         r_pend_rpt <= w_pend_rpt_d;
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         r_beep     <= w_pop;
         r_ovf      <= r_ovf | w_drop;
      end
   end

   // Storage needs no reset: the head is masked whenever the FIFO is empty.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr[IDX_W-1:0]] <= w_push_evt;
   end

   assign o_evt_valid = !w_empty;
   assign o_evt_code  = w_empty ? '0 : w_head.code;
   assign o_evt_rpt   = w_empty ? 1'b0 : w_head.rpt;
   assign o_beep_req  = r_beep;
   assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_key_event_encoder.sv
// Bench for key_event_encoder: directed vector table, corner sequences, random run vs model.
module tb_key_event_encoder;

   localparam int DEB = 8;
   localparam int HLD = 40;
   localparam int REP = 10;
   localparam int FD  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] key = 4'hF;
   logic       ready = 1'b0;
   logic [3:0] key_value, key_flag;
   logic       evt_valid, evt_rpt, beep_req, ovf;
   logic [1:0] evt_code;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   key_event_encoder #(
      .DEBOUNCE_CYC (DEB),
      .HOLD_CYC     (HLD),
      .REPEAT_CYC   (REP),
      .FIFO_DEPTH   (FD)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_key       (key),
      .o_key_value (key_value),
      .o_key_flag  (key_flag),
      .o_evt_valid (evt_valid),
      .o_evt_code  (evt_code),
      .o_evt_rpt   (evt_rpt),
      .i_evt_ready (ready),
      .o_beep_req  (beep_req),
      .o_ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: run lengths of the synchronized level per key, events as a list.
   int         m_zrun [4], m_run [4], m_rel [4], m_age [4];
   bit         m_armed [4], m_pressed [4], m_repeating [4];
   logic [3:0] m_value, m_flag, m_flag_rpt, m_pend, m_pend_rpt, m_dl0, m_dl1;
   logic [2:0] m_fifo [FD];
   int         m_cnt;
   logic       m_beep, m_ovf;

   always @(posedge clk) begin : ref_model
      int zr [4], rn [4], rl [4], ag [4];
      bit ar [4], pr [4], rp [4];
      logic [3:0] s, val, flg, frp, pend, prpt;
      logic [2:0] lf [FD];
      int lc, sel;
      bit pop, ov;
      if (rst) begin
         m_zrun <= '{default: 0};  m_run <= '{default: 0};
         m_rel <= '{default: 0};   m_age <= '{default: 0};
         m_armed <= '{default: 0}; m_pressed <= '{default: 0};
         m_repeating <= '{default: 0};
         m_value <= '0; m_flag <= '0; m_flag_rpt <= '0; m_pend <= '0; m_pend_rpt <= '0;
         m_dl0 <= 4'hF; m_dl1 <= 4'hF; m_cnt <= 0; m_beep <= 1'b0; m_ovf <= 1'b0;
      end else begin
         zr = m_zrun; rn = m_run; rl = m_rel; ag = m_age;
         ar = m_armed; pr = m_pressed; rp = m_repeating;
         s = ~m_dl1; val = m_value; flg = '0; frp = '0;
         for (int k = 0; k < 4; k++) begin
            if (!ar[k]) begin
               if (s[k]) zr[k] = 0;
               else begin
                  zr[k]++;
                  if (zr[k] == DEB) begin ar[k] = 1; zr[k] = 0; end
               end
            end else if (!pr[k]) begin
               if (s[k]) begin
                  rn[k]++;
                  if (rn[k] == DEB + 1) begin
                     pr[k] = 1; val[k] = 1; flg[k] = 1; rp[k] = 0; ag[k] = 0; rl[k] = 0;
                  end
               end else rn[k] = 0;
            end else if (!s[k]) begin
               rl[k]++;
               if (rl[k] == DEB + 1) begin pr[k] = 0; val[k] = 0; rn[k] = 0; rl[k] = 0; end
            end else if (rl[k] > 0) begin
               rl[k] = 0; ag[k] = 0;
            end else begin
               ag[k]++;
               if (ag[k] == (rp[k] ? REP : HLD)) begin
                  flg[k] = 1; frp[k] = 1; rp[k] = 1; ag[k] = 0;
               end
            end
         end
         lf = m_fifo; lc = m_cnt; pend = m_pend; prpt = m_pend_rpt; ov = m_ovf;
         pop = (lc > 0) && ready;
         sel = -1;
         for (int k = 3; k >= 0; k--) if (m_pend[k]) sel = k;
         if (pop) begin
            for (int j = 0; j < FD - 1; j++) lf[j] = lf[j+1];
            lc--;
         end
         if (sel >= 0 && (m_cnt < FD || pop)) begin
            lf[lc] = {m_pend_rpt[sel], 2'(sel)};
            lc++;
            pend[sel] = 1'b0;
         end
         for (int k = 0; k < 4; k++) begin
            if (m_flag[k]) begin
               if (pend[k]) ov = 1;
               else begin pend[k] = 1'b1; prpt[k] = m_flag_rpt[k]; end
            end
         end
         m_zrun <= zr; m_run <= rn; m_rel <= rl; m_age <= ag;
         m_armed <= ar; m_pressed <= pr; m_repeating <= rp;
         m_value <= val; m_flag <= flg; m_flag_rpt <= frp;
         m_pend <= pend; m_pend_rpt <= prpt; m_fifo <= lf; m_cnt <= lc;
         m_beep <= pop; m_ovf <= ov; m_dl1 <= m_dl0; m_dl0 <= key;
      end
   end

   logic [2:0] log_q [$];
   int         n_beep = 0;

   always @(negedge clk) begin
      logic [13:0] act, exp;
      if (chk_en) begin
         act = {key_value, key_flag, evt_valid, evt_code, evt_rpt, beep_req, ovf};
         exp = {m_value, m_flag, m_cnt > 0, (m_cnt > 0) ? m_fifo[0][1:0] : 2'b00,
                (m_cnt > 0) ? m_fifo[0][2] : 1'b0, m_beep, m_ovf};
         check("cycle_outputs", 32'(act), 32'(exp));
         if (evt_valid && ready) log_q.push_back({evt_rpt, evt_code});
         if (beep_req) n_beep++;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input int k, input int hold, input int rel);
      key[k] = 1'b0;
      step(hold);
      key[k] = 1'b1;
      step(rel);
   endtask

   typedef struct {
      logic [3:0] mask;
      int         hold;
      int         exp_evts;
      int         exp_rpts;
      int         code0;
      int         code1;
   } vec_t;

   vec_t vecs [4];
   int   seq_a [5];
   int   dur [4];
   int   nrpt;

   initial begin
      vecs[0] = '{mask: 4'b0010, hold: 5,  exp_evts: 0, exp_rpts: 0, code0: 0, code1: 0};
      vecs[1] = '{mask: 4'b0010, hold: 20, exp_evts: 1, exp_rpts: 0, code0: 1, code1: 0};
      vecs[2] = '{mask: 4'b1000, hold: 80, exp_evts: 5, exp_rpts: 4, code0: 3, code1: 3};
      vecs[3] = '{mask: 4'b0101, hold: 20, exp_evts: 2, exp_rpts: 0, code0: 0, code1: 2};
      seq_a = '{0, 1, 2, 3, 0};

      rst = 1'b1;
      step(3);
      check("reset_outputs", 32'({key_value, key_flag, evt_valid, evt_code, beep_req, ovf}), 0);
      rst = 1'b0;
      chk_en = 1'b1;
      ready = 1'b1;
      step(15);

      for (int v = 0; v < 4; v++) begin
         log_q.delete();
         n_beep = 0;
         key = ~vecs[v].mask;
         step(vecs[v].hold);
         key = 4'hF;
         step(40);
         check("vec_events", 32'(log_q.size()), 32'(vecs[v].exp_evts));
         check("vec_beeps", 32'(n_beep), 32'(vecs[v].exp_evts));
         check("vec_released", 32'(key_value), 0);
         nrpt = 0;
         foreach (log_q[i]) nrpt += int'(log_q[i][2]);
         check("vec_repeats", 32'(nrpt), 32'(vecs[v].exp_rpts));
         if (log_q.size() > 0) check("vec_code0", 32'(log_q[0][1:0]), 32'(vecs[v].code0));
         if (log_q.size() > 1) check("vec_code1", 32'(log_q[1][1:0]), 32'(vecs[v].code1));
      end

      // Fill the FIFO, park one more in pending, then overflow pending.
      ready = 1'b0;
      for (int k = 0; k < 4; k++) press(k, 20, 20);
      press(0, 20, 20);
      check("full_valid", 32'(evt_valid), 1);
      check("full_head", 32'(evt_code), 0);
      check("full_no_ovf", 32'(ovf), 0);
      press(0, 20, 20);
      check("ovf_set", 32'(ovf), 1);
      log_q.delete();
      ready = 1'b1;
      step(20);
      check("drain_count", 32'(log_q.size()), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < log_q.size()) check("drain_order", 32'(log_q[i]), 32'(seq_a[i]));
      end
      check("ovf_sticky", 32'(ovf), 1);

      // Reset while key 2 is held with events queued; it must be released and re-pressed.
      ready = 1'b0;
      press(0, 20, 20);
      press(1, 20, 20);
      key[2] = 1'b0;
      step(14);
      check("pre_rst_value", 32'(key_value[2]), 1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check("rst_outputs", 32'({key_value, key_flag, evt_valid, evt_code, beep_req, ovf}), 0);
      ready = 1'b1;
      log_q.delete();
      step(60);
      check("rst_held_no_evt", 32'(log_q.size()), 0);
      check("rst_held_value", 32'(key_value), 0);
      key[2] = 1'b1;
      step(30);
      press(2, 20, 30);
      check("repress_count", 32'(log_q.size()), 1);
      if (log_q.size() > 0) check("repress_code", 32'(log_q[0]), 2);

      // Random run against the model.
      for (int k = 0; k < 4; k++) dur[k] = 0;
      for (int c = 0; c < 4000; c++) begin
         for (int k = 0; k < 4; k++) begin
            if (dur[k] == 0) begin
               key[k] = ~key[k];
               dur[k] = $urandom_range(1, 70);
            end else dur[k]--;
         end
         ready = ($urandom_range(0, 2) != 0);
         rst = ($urandom_range(0, 999) == 0);
         step(1);
      end
      rst = 1'b0;
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
